// File: rtl/ps2_key_ctrl.sv
// Sequencer between the ps2_keyboard receive FIFO and the key consumers.
// It pops one byte at a time, folds the E0/F0 prefixes, and emits one event per scan-code sequence.
module ps2_key_ctrl #(
  parameter int          CNT_W    = 12,
  parameter logic [7:0]  BRK_CODE = 8'hF0,
  parameter logic [7:0]  EXT_CODE = 8'hE0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ready,
  input  logic [7:0]       data,
  input  logic             overflow,
  input  logic             clr_ovf,
  output logic             nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_break,
  output logic             key_down,
  output logic [7:0]       held_code,
  output logic             held_ext,
  output logic [CNT_W-1:0] press_count,
  output logic             ovf_seen
);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    DECODE
  } state_t;

  state_t     state;
  logic [7:0] byte_r;
  logic       ext;
  logic       brk;

  // An overflow in the decode cycle discards the prefixes gathered so far.
  logic ext_eff;
  logic brk_eff;
  logic is_ext;
  logic is_brk;
  logic held_match;

  assign ext_eff    = ext & ~overflow;
  assign brk_eff    = brk & ~overflow;
  assign is_ext     = (byte_r == EXT_CODE);
  assign is_brk     = (byte_r == BRK_CODE);
  assign held_match = key_down && ({held_ext, held_code} == {ext_eff, byte_r});

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      byte_r      <= 8'h00;
      ext         <= 1'b0;
      brk         <= 1'b0;
      nextdata_n  <= 1'b1;
      key_valid   <= 1'b0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_break   <= 1'b0;
      key_down    <= 1'b0;
      held_code   <= 8'h00;
      held_ext    <= 1'b0;
      press_count <= '0;
      ovf_seen    <= 1'b0;
    end else begin
      key_valid <= 1'b0;

      if (overflow) begin
        ovf_seen <= 1'b1;
        ext      <= 1'b0;
        brk      <= 1'b0;
      end else if (clr_ovf) begin
        ovf_seen <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (ready) begin
            byte_r     <= data;
            nextdata_n <= 1'b0;
            state      <= ACK;
          end
        end

        ACK: begin
          nextdata_n <= 1'b1;
          state      <= DECODE;
        end

        DECODE: begin
          state <= IDLE;
          if (is_ext) begin
            ext <= 1'b1;
          end else if (is_brk) begin
            brk <= 1'b1;
          end else begin
            key_valid <= 1'b1;
            key_code  <= byte_r;
            key_ext   <= ext_eff;
            key_break <= brk_eff;
            ext       <= 1'b0;
            brk       <= 1'b0;
            if (brk_eff) begin
              // Releasing a key other than the held one leaves the held state alone.
              if (held_match) begin
                key_down <= 1'b0;
              end
            end else begin
              if (!held_match) begin
                press_count <= press_count + CNT_W'(1);
              end
              held_code <= byte_r;
              held_ext  <= ext_eff;
              key_down  <= 1'b1;
            end
          end
        end

        default: begin
          nextdata_n <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: a small FIFO model feeds bytes, a table holds the expected results.
module tb_ps2_key_ctrl;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             ready;
  logic [7:0]       data;
  logic             overflow;
  logic             clr_ovf;
  logic             nextdata_n;
  logic             key_valid;
  logic [7:0]       key_code;
  logic             key_ext;
  logic             key_break;
  logic             key_down;
  logic [7:0]       held_code;
  logic             held_ext;
  logic [CNT_W-1:0] press_count;
  logic             ovf_seen;

  always #5 clk = ~clk;

  ps2_key_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ready(ready), .data(data), .overflow(overflow),
    .clr_ovf(clr_ovf), .nextdata_n(nextdata_n), .key_valid(key_valid),
    .key_code(key_code), .key_ext(key_ext), .key_break(key_break),
    .key_down(key_down), .held_code(held_code), .held_ext(held_ext),
    .press_count(press_count), .ovf_seen(ovf_seen)
  );

  // FIFO model: pops on a rising edge while nextdata_n is low
  logic [7:0] fifo_mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign ready = (wr_ptr != rd_ptr);
  assign data  = fifo_mem[rd_ptr[5:0]];
  always @(posedge clk) if (!nextdata_n && ready) rd_ptr <= rd_ptr + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr[5:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  // Called at a falling edge with the DUT idle; returns at the falling edge where the event would show.
  task automatic apply_byte(input logic [7:0] b, output logic nd1, output logic nd2, output logic v);
    push(b);
    @(negedge clk); nd1 = nextdata_n;
    @(negedge clk); nd2 = nextdata_n;
    @(negedge clk); v   = key_valid;
  endtask

  typedef struct {
    logic [7:0] b;
    logic       v;
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       down;
    logic [7:0] hcode;
    logic       hext;
    int         cnt;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] b, input logic v, input logic [7:0] code,
                              input logic ext, input logic brk, input logic down,
                              input logic [7:0] hcode, input logic hext, input int cnt);
    vec_t r;
    r.b = b; r.v = v; r.code = code; r.ext = ext; r.brk = brk;
    r.down = down; r.hcode = hcode; r.hext = hext; r.cnt = cnt;
    return r;
  endfunction

  vec_t tbl [0:20];

  task automatic chk_reset_vals(input string tag);
    chk({tag, " nextdata_n"}, 32'(nextdata_n), 32'd1);
    chk({tag, " key_valid"}, 32'(key_valid), 32'd0);
    chk({tag, " key_code"}, 32'(key_code), 32'd0);
    chk({tag, " key_ext"}, 32'(key_ext), 32'd0);
    chk({tag, " key_break"}, 32'(key_break), 32'd0);
    chk({tag, " key_down"}, 32'(key_down), 32'd0);
    chk({tag, " held_code"}, 32'(held_code), 32'd0);
    chk({tag, " held_ext"}, 32'(held_ext), 32'd0);
    chk({tag, " press_count"}, 32'(press_count), 32'd0);
    chk({tag, " ovf_seen"}, 32'(ovf_seen), 32'd0);
  endtask

  initial begin
    logic nd1, nd2, v;
    logic nd_seq [1:11];
    logic kv_seq [1:11];

    // byte, valid, key_code, key_ext, key_break, key_down, held_code, held_ext, press_count
    tbl[0]  = mk(8'h1C, 1, 8'h1C, 0, 0, 1, 8'h1C, 0, 1);
    tbl[1]  = mk(8'h1C, 1, 8'h1C, 0, 0, 1, 8'h1C, 0, 1);
    tbl[2]  = mk(8'h1C, 1, 8'h1C, 0, 0, 1, 8'h1C, 0, 1);
    tbl[3]  = mk(8'hF0, 0, 8'h1C, 0, 0, 1, 8'h1C, 0, 1);
    tbl[4]  = mk(8'h1C, 1, 8'h1C, 0, 1, 0, 8'h1C, 0, 1);
    tbl[5]  = mk(8'hE0, 0, 8'h1C, 0, 1, 0, 8'h1C, 0, 1);
    tbl[6]  = mk(8'h75, 1, 8'h75, 1, 0, 1, 8'h75, 1, 2);
    tbl[7]  = mk(8'hE0, 0, 8'h75, 1, 0, 1, 8'h75, 1, 2);
    tbl[8]  = mk(8'hF0, 0, 8'h75, 1, 0, 1, 8'h75, 1, 2);
    tbl[9]  = mk(8'h75, 1, 8'h75, 1, 1, 0, 8'h75, 1, 2);
    tbl[10] = mk(8'h1C, 1, 8'h1C, 0, 0, 1, 8'h1C, 0, 3);
    tbl[11] = mk(8'h32, 1, 8'h32, 0, 0, 1, 8'h32, 0, 0);
    tbl[12] = mk(8'h1C, 1, 8'h1C, 0, 0, 1, 8'h1C, 0, 1);
    tbl[13] = mk(8'h32, 1, 8'h32, 0, 0, 1, 8'h32, 0, 2);
    tbl[14] = mk(8'h1C, 1, 8'h1C, 0, 0, 1, 8'h1C, 0, 3);
    tbl[15] = mk(8'hF0, 0, 8'h1C, 0, 0, 1, 8'h1C, 0, 3);
    tbl[16] = mk(8'h32, 1, 8'h32, 0, 1, 1, 8'h1C, 0, 3);
    tbl[17] = mk(8'hE0, 0, 8'h32, 0, 1, 1, 8'h1C, 0, 3);
    tbl[18] = mk(8'hE0, 0, 8'h32, 0, 1, 1, 8'h1C, 0, 3);
    tbl[19] = mk(8'hF0, 0, 8'h32, 0, 1, 1, 8'h1C, 0, 3);
    tbl[20] = mk(8'h75, 1, 8'h75, 1, 1, 1, 8'h1C, 0, 3);

    rst = 1'b1; overflow = 1'b0; clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 21; i++) begin
      apply_byte(tbl[i].b, nd1, nd2, v);
      $display("vec %0d: byte %02h valid %0b code %02h ext %0b brk %0b down %0b cnt %0d",
               i, tbl[i].b, v, key_code, key_ext, key_break, key_down, press_count);
      chk($sformatf("v%0d pop_low", i), 32'(nd1), 32'd0);
      chk($sformatf("v%0d pop_high", i), 32'(nd2), 32'd1);
      chk($sformatf("v%0d key_valid", i), 32'(v), 32'(tbl[i].v));
      chk($sformatf("v%0d key_code", i), 32'(key_code), 32'(tbl[i].code));
      chk($sformatf("v%0d key_ext", i), 32'(key_ext), 32'(tbl[i].ext));
      chk($sformatf("v%0d key_break", i), 32'(key_break), 32'(tbl[i].brk));
      chk($sformatf("v%0d key_down", i), 32'(key_down), 32'(tbl[i].down));
      chk($sformatf("v%0d held_code", i), 32'(held_code), 32'(tbl[i].hcode));
      chk($sformatf("v%0d held_ext", i), 32'(held_ext), 32'(tbl[i].hext));
      chk($sformatf("v%0d press_count", i), 32'(press_count), 32'(tbl[i].cnt));
    end

    // Overflow after a break prefix discards it
    chk("ovf idle", 32'(ovf_seen), 32'd0);
    apply_byte(8'hF0, nd1, nd2, v);
    overflow = 1'b1;
    @(negedge clk);
    overflow = 1'b0;
    chk("ovf set", 32'(ovf_seen), 32'd1);
    apply_byte(8'h1C, nd1, nd2, v);
    $display("ovf seq: valid %0b code %02h brk %0b cnt %0d ovf %0b", v, key_code, key_break, press_count, ovf_seen);
    chk("ovf key_valid", 32'(v), 32'd1);
    chk("ovf key_code", 32'(key_code), 32'h1C);
    chk("ovf key_break", 32'(key_break), 32'd0);
    chk("ovf key_down", 32'(key_down), 32'd1);
    chk("ovf press_count", 32'(press_count), 32'd3);
    chk("ovf sticky", 32'(ovf_seen), 32'd1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("ovf clear", 32'(ovf_seen), 32'd0);
    clr_ovf = 1'b1; overflow = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0; overflow = 1'b0;
    chk("ovf set_wins", 32'(ovf_seen), 32'd1);

    // Back-to-back bytes with a reset landing in the ACK of byte 2
    push(8'h2A); push(8'h3B); push(8'hE0); push(8'h4C);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      nd_seq[k] = nextdata_n;
      kv_seq[k] = key_valid;
      if (k == 3) chk("b2b key_code", 32'(key_code), 32'h2A);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("b2b reset: nd %0b%0b%0b%0b fifo_left %0d", nd_seq[1], nd_seq[2], nd_seq[3], nd_seq[4], wr_ptr - rd_ptr);
    chk("b2b pop1", 32'(nd_seq[1]), 32'd0);
    chk("b2b gap1", 32'(nd_seq[2]), 32'd1);
    chk("b2b gap2", 32'(nd_seq[3]), 32'd1);
    chk("b2b pop2", 32'(nd_seq[4]), 32'd0);
    chk("b2b valid1", 32'(kv_seq[3]), 32'd1);
    chk("b2b fifo_left", 32'(wr_ptr - rd_ptr), 32'd2);
    chk_reset_vals("rst_mid");
    for (int k = 6; k <= 11; k++) begin
      @(negedge clk);
      nd_seq[k] = nextdata_n;
      kv_seq[k] = key_valid;
    end
    $display("post reset: valid %0b code %02h ext %0b brk %0b down %0b cnt %0d", kv_seq[11], key_code, key_ext, key_break, key_down, press_count);
    chk("post pop3", 32'(nd_seq[6]), 32'd0);
    chk("post pop4", 32'(nd_seq[9]), 32'd0);
    chk("post gap", 32'(nd_seq[8]), 32'd1);
    chk("post prefix_quiet", 32'(kv_seq[8]), 32'd0);
    chk("post valid", 32'(kv_seq[11]), 32'd1);
    chk("post key_code", 32'(key_code), 32'h4C);
    chk("post key_ext", 32'(key_ext), 32'd1);
    chk("post key_break", 32'(key_break), 32'd0);
    chk("post key_down", 32'(key_down), 32'd1);
    chk("post held_ext", 32'(held_ext), 32'd1);
    chk("post press_count", 32'(press_count), 32'd1);
    chk("post fifo_empty", 32'(ready), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
